vga_cmd_port: RTL and testbench

- Responder end of the VGA command port: accepts cmd/cursor/data transactions from an initiator such as cur_wr_char or the SPI bridge.
- Executes each command against text video RAM and cursor state, and drives the ready_h handshake back to the initiator.
- Sits inside vga_top between the command-port pins and the VRAM write/read port and cursor inputs of the text renderer.
- Text mode is 80x25 cells, one byte per cell, linear address = row*COLS + col.

---
 rtl/vga_cmd_pkg.sv | 39 +++
 rtl/vga_cmd_port_cursor_ctr.sv | 45 ++++
 rtl/vga_cmd_port.sv | 189 ++++++++++++++++++
 tb/tb_vga_cmd_port.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cmd_pkg.sv
// ---------------------------------------------------------------------------
// vga_cmd_pkg
// Shared definitions for the VGA command port and its initiators
// (cur_wr_char, the SPI bridge): screen geometry, command codes and the
// responder state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_cmd_pkg;

    // Text-mode geometry: one byte per cell, linear address = row*COLS + col
    localparam int COLS         = 80;
    localparam int ROWS         = 25;
    localparam int ADDR_W       = 11;
    localparam int SCREEN_CELLS = COLS * ROWS;

    // Highest valid cell address, pre-sized to the address width
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(SCREEN_CELLS - 1);

    // Byte written to every cell by CLEAR (ASCII space)
    localparam logic [7:0] FILL_CHAR = 8'h20;

    // Command codes; anything else behaves as NOP
    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_SET_CURSOR = 8'h01;
    localparam logic [7:0] CMD_DATA       = 8'h02;
    localparam logic [7:0] CMD_CLEAR      = 8'h03;
    localparam logic [7:0] CMD_CURSOR_ON  = 8'h04;
    localparam logic [7:0] CMD_CURSOR_OFF = 8'h05;

    // Responder states
    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        RD_WAIT,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/vga_cmd_port_cursor_ctr.sv
// ---------------------------------------------------------------------------
// vga_cursor_ctr
// Holds the text cursor position. Supports a clamped load, an increment that
// wraps from the last cell back to 0, and a clear to 0.
// Ports:
//   i_clk, i_rst   clock / async active-high reset (cursor -> 0)
//   i_clr          force cursor to 0 (highest priority)
//   i_load         load i_load_addr, clamped to the last cell
//   i_load_addr    requested cursor address
//   i_inc          advance by one with wrap
//   o_addr         current cursor position
// ---------------------------------------------------------------------------
module vga_cursor_ctr
    import vga_cmd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_addr;

    // Cursor register. Clear wins over load, load wins over increment; the
    // FSM never asks for more than one at a time, the priority just keeps
    // the behaviour defined. Out-of-range loads stick at the last cell so
    // the renderer never sees an address off the screen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= (i_load_addr > LAST_CELL) ? LAST_CELL : i_load_addr;
        end else if (i_inc) begin
            r_addr <= (r_addr == LAST_CELL) ? '0 : r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/vga_cmd_port.sv
// ---------------------------------------------------------------------------
// vga_cmd_port
// Responder end of the VGA command port. Accepts one command per i_cs_h
// transaction, executes it against text VRAM and the cursor state, and
// reports completion through o_ready_h.
// Ports:
//   i_clk, i_rst        pixel clock / async active-high reset
//   i_cmd               command code, sampled on the accept edge
//   i_cur_adr           cursor operand for SET_CURSOR
//   i_port / o_port     write data operand / last read result
//   i_cs_h              transaction request
//   i_rl_wh             DATA direction: 0 read, 1 write
//   o_ready_h           1 when idle and able to accept a command
//   o_vram_addr/data/we VRAM write/read port (we is one cycle per byte)
//   i_vram_data         VRAM read data, one cycle after o_vram_addr
//   o_cursor_addr/en    cursor position and visibility to the renderer
// ---------------------------------------------------------------------------
module vga_cmd_port
    import vga_cmd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_cmd,
    input  logic [ADDR_W-1:0] i_cur_adr,
    input  logic [7:0]        i_port,
    output logic [7:0]        o_port,
    input  logic              i_cs_h,
    input  logic              i_rl_wh,
    output logic              o_ready_h,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [7:0]        o_vram_data,
    output logic              o_vram_we,
    input  logic [7:0]        i_vram_data,
    output logic [ADDR_W-1:0] o_cursor_addr,
    output logic              o_cursor_en
);

    state_t            r_state, w_nextState;
    logic [7:0]        r_cmd;
    logic [ADDR_W-1:0] r_curAdr;
    logic [7:0]        r_portIn;
    logic              r_rlWh;
    logic [7:0]        r_portOut;
    logic              r_cursorEn;
    logic [ADDR_W-1:0] r_fillAddr;

    logic              w_accept;
    logic              w_lastFill;
    logic              w_curLoad;
    logic              w_curInc;
    logic              w_curClr;
    logic [ADDR_W-1:0] w_cursor;

    assign w_accept   = (r_state == IDLE) && i_cs_h;
    assign w_lastFill = (r_fillAddr == LAST_CELL);

    // State register. Reset lands in IDLE, which also makes every
    // state-decoded output (we, ready, addresses) return to its rest value
    // immediately, so an in-progress CLEAR stops writing at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and VRAM/cursor control. VRAM outputs are decoded from the
    // state so the write strobe exists only in EXEC (DATA write) and FILL.
    // The address defaults to the cursor, which is what both DATA
    // directions want; RD_WAIT keeps it there while the read data arrives.
    // DONE waits for i_cs_h to fall so a held request is executed only once.
    always_comb begin
        w_nextState = r_state;
        o_vram_we   = 1'b0;
        o_vram_addr = w_cursor;
        o_vram_data = 8'h00;
        w_curLoad   = 1'b0;
        w_curInc    = 1'b0;
        w_curClr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cs_h) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                case (r_cmd)
                    CMD_SET_CURSOR: begin
                        w_curLoad   = 1'b1;
                        w_nextState = DONE;
                    end
                    CMD_DATA: begin
                        if (r_rlWh) begin
                            o_vram_we   = 1'b1;
                            o_vram_data = r_portIn;
                            w_curInc    = 1'b1;
                            w_nextState = DONE;
                        end else begin
                            w_nextState = RD_WAIT;
                        end
                    end
                    CMD_CLEAR: begin
                        w_nextState = FILL;
                    end
                    default: begin
                        w_nextState = DONE;
                    end
                endcase
            end
            RD_WAIT: begin
                w_curInc    = 1'b1;
                w_nextState = DONE;
            end
            FILL: begin
                o_vram_we   = 1'b1;
                o_vram_addr = r_fillAddr;
                o_vram_data = FILL_CHAR;
                if (w_lastFill) begin
                    w_curClr    = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (!i_cs_h) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers: operands are captured only on the accept edge so
    // later changes on the pins are ignored. Cursor visibility changes in
    // EXEC, the fill address runs during FILL, and the read result is
    // captured in RD_WAIT and otherwise held (writes never clear it).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd      <= CMD_NOP;
            r_curAdr   <= '0;
            r_portIn   <= 8'h00;
            r_rlWh     <= 1'b0;
            r_portOut  <= 8'h00;
            r_cursorEn <= 1'b1;
            r_fillAddr <= '0;
        end else begin
            if (w_accept) begin
                r_cmd    <= i_cmd;
                r_curAdr <= i_cur_adr;
                r_portIn <= i_port;
                r_rlWh   <= i_rl_wh;
            end
            if (r_state == EXEC) begin
                if (r_cmd == CMD_CURSOR_ON) begin
                    r_cursorEn <= 1'b1;
                end else if (r_cmd == CMD_CURSOR_OFF) begin
                    r_cursorEn <= 1'b0;
                end
                if (r_cmd == CMD_CLEAR) begin
                    r_fillAddr <= '0;
                end
            end
            if (r_state == FILL && !w_lastFill) begin
                r_fillAddr <= r_fillAddr + 1'b1;
            end
            if (r_state == RD_WAIT) begin
                r_portOut <= i_vram_data;
            end
        end
    end

    vga_cursor_ctr u_cursor (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_curClr),
        .i_load      (w_curLoad),
        .i_load_addr (r_curAdr),
        .i_inc       (w_curInc),
        .o_addr      (w_cursor)
    );

    assign o_ready_h     = (r_state == IDLE);
    assign o_port        = r_portOut;
    assign o_cursor_addr = w_cursor;
    assign o_cursor_en   = r_cursorEn;

endmodule

// File: tb/tb_vga_cmd_port.sv
// ---------------------------------------------------------------------------
// tb_vga_cmd_port
// Directed self-checking bench for vga_cmd_port with a small VRAM model.
// ---------------------------------------------------------------------------
module tb_vga_cmd_port;

    logic        clk;
    logic        rst;
    logic [7:0]  cmdIn;
    logic [10:0] curAdr;
    logic [7:0]  portIn;
    logic [7:0]  portOut;
    logic        csH;
    logic        rlWh;
    logic        readyH;
    logic [10:0] vramAddr;
    logic [7:0]  vramWrData;
    logic        vramWe;
    logic [7:0]  vramRdData;
    logic [10:0] cursorAddr;
    logic        cursorEn;

    logic [7:0]  vram [0:2047];
    int          weCount;
    int          fillRunLen;
    logic [10:0] lastAddr;
    logic [7:0]  lastData;

    int testCount;
    int failCount;

    vga_cmd_port dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd         (cmdIn),
        .i_cur_adr     (curAdr),
        .i_port        (portIn),
        .o_port        (portOut),
        .i_cs_h        (csH),
        .i_rl_wh       (rlWh),
        .o_ready_h     (readyH),
        .o_vram_addr   (vramAddr),
        .o_vram_data   (vramWrData),
        .o_vram_we     (vramWe),
        .i_vram_data   (vramRdData),
        .o_cursor_addr (cursorAddr),
        .o_cursor_en   (cursorEn)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM model with one-cycle read latency, plus a write monitor. fillRunLen
    // counts the current run of consecutive FILL_CHAR writes starting at 0.
    always @(posedge clk) begin
        vramRdData <= vram[vramAddr];
        if (vramWe) begin
            vram[vramAddr] <= vramWrData;
            weCount        <= weCount + 1;
            lastAddr       <= vramAddr;
            lastData       <= vramWrData;
            if (vramWrData == 8'h20 && vramAddr == 11'(fillRunLen)) begin
                fillRunLen <= fillRunLen + 1;
            end else if (vramWrData == 8'h20 && vramAddr == 11'd0) begin
                fillRunLen <= 1;
            end else begin
                fillRunLen <= 0;
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One complete transaction: present operands, raise cs for the accept
    // edge, optionally hold cs (scrambling operands), drop it, then wait for
    // ready. waitCycles = negedges from cs falling to ready high.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [10:0] adr,
                                 input logic [7:0] data, input logic dir,
                                 input int holdCycles, output int waitCycles,
                                 output int readyDuringHold);
        @(negedge clk);
        cmdIn  = cmd;
        curAdr = adr;
        portIn = data;
        rlWh   = dir;
        csH    = 1'b1;
        @(negedge clk);
        checkOutput("ready_drop", 32'(readyH), 32'd0);
        readyDuringHold = 0;
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clk);
            portIn = ~data;
            curAdr = ~adr;
            if (readyH) readyDuringHold++;
        end
        csH    = 1'b0;
        cmdIn  = 8'h02;
        portIn = 8'hEE;
        waitCycles = 0;
        while (readyH !== 1'b1 && waitCycles < 3000) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("ready_return", 32'(readyH), 32'd1);
    endtask

    initial begin
        int n;
        int hi;
        int weBase;

        testCount = 0;
        failCount = 0;
        weCount    = 0;
        fillRunLen = 0;
        lastAddr   = '0;
        lastData   = '0;
        rst    = 1'b1;
        cmdIn  = 8'h00;
        curAdr = '0;
        portIn = 8'h00;
        csH    = 1'b0;
        rlWh   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_ready",   32'(readyH),     32'd1);
        checkOutput("rst_port",    32'(portOut),    32'd0);
        checkOutput("rst_we",      32'(vramWe),     32'd0);
        checkOutput("rst_vaddr",   32'(vramAddr),   32'd0);
        checkOutput("rst_vdata",   32'(vramWrData), 32'd0);
        checkOutput("rst_cursor",  32'(cursorAddr), 32'd0);
        checkOutput("rst_cur_en",  32'(cursorEn),   32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(readyH), 32'd1);

        // Cursor to last cell, then write wraps the cursor
        applyStimulus(8'h01, 11'd1999, 8'h00, 1'b0, 0, n, hi);
        checkOutput("setcur_1999", 32'(cursorAddr), 32'd1999);
        checkOutput("setcur_wait", 32'(n), 32'd2);
        weBase = weCount;
        applyStimulus(8'h02, 11'd0, 8'h41, 1'b1, 0, n, hi);
        checkOutput("wr41_pulses", 32'(weCount - weBase), 32'd1);
        checkOutput("wr41_addr",   32'(lastAddr), 32'd1999);
        checkOutput("wr41_data",   32'(lastData), 32'h41);
        checkOutput("wr41_wrap",   32'(cursorAddr), 32'd0);
        checkOutput("wr41_wait",   32'(n), 32'd2);

        // Out-of-range cursor clamps
        applyStimulus(8'h01, 11'd2047, 8'h00, 1'b0, 0, n, hi);
        checkOutput("setcur_clamp", 32'(cursorAddr), 32'd1999);

        // Write 0x55 at 10, read it back
        applyStimulus(8'h01, 11'd10, 8'h00, 1'b0, 0, n, hi);
        applyStimulus(8'h02, 11'd0, 8'h55, 1'b1, 0, n, hi);
        checkOutput("wr55_cursor", 32'(cursorAddr), 32'd11);
        applyStimulus(8'h01, 11'd10, 8'h00, 1'b0, 0, n, hi);
        applyStimulus(8'h02, 11'd0, 8'hAA, 1'b0, 0, n, hi);
        checkOutput("rd_port",   32'(portOut),    32'h55);
        checkOutput("rd_cursor", 32'(cursorAddr), 32'd11);
        checkOutput("rd_wait",   32'(n), 32'd3);

        // A write does not disturb the held read result
        applyStimulus(8'h02, 11'd0, 8'h66, 1'b1, 0, n, hi);
        checkOutput("port_hold", 32'(portOut), 32'h55);

        // Held cs on a write: one pulse, operands changed mid-hold ignored
        weBase = weCount;
        applyStimulus(8'h02, 11'd0, 8'h77, 1'b1, 20, n, hi);
        checkOutput("hold_pulses",   32'(weCount - weBase), 32'd1);
        checkOutput("hold_data",     32'(lastData), 32'h77);
        checkOutput("hold_addr",     32'(lastAddr), 32'd12);
        checkOutput("hold_ready_lo", 32'(hi), 32'd0);
        checkOutput("hold_wait",     32'(n), 32'd1);
        checkOutput("hold_cursor",   32'(cursorAddr), 32'd13);

        // Cursor visibility and unknown command
        applyStimulus(8'h05, 11'd0, 8'h00, 1'b0, 0, n, hi);
        checkOutput("cur_off", 32'(cursorEn), 32'd0);
        weBase = weCount;
        applyStimulus(8'h7F, 11'd5, 8'h12, 1'b1, 0, n, hi);
        checkOutput("bad_cmd_en",     32'(cursorEn),   32'd0);
        checkOutput("bad_cmd_cursor", 32'(cursorAddr), 32'd13);
        checkOutput("bad_cmd_we",     32'(weCount - weBase), 32'd0);
        applyStimulus(8'h04, 11'd0, 8'h00, 1'b0, 0, n, hi);
        checkOutput("cur_on", 32'(cursorEn), 32'd1);

        // Full CLEAR
        weBase = weCount;
        applyStimulus(8'h03, 11'd0, 8'h00, 1'b0, 0, n, hi);
        checkOutput("clr_pulses", 32'(weCount - weBase), 32'd2000);
        checkOutput("clr_run",    32'(fillRunLen), 32'd2000);
        checkOutput("clr_wait",   32'(n), 32'd2002);
        checkOutput("clr_cursor", 32'(cursorAddr), 32'd0);
        checkOutput("clr_cell12", 32'(vram[12]), 32'h20);

        // Reset in the middle of a CLEAR
        applyStimulus(8'h01, 11'd300, 8'h00, 1'b0, 0, n, hi);
        @(negedge clk);
        cmdIn = 8'h03;
        csH   = 1'b1;
        @(negedge clk);
        csH = 1'b0;
        n = 0;
        while (!(vramWe === 1'b1 && vramAddr == 11'd500) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fill_reach_500", 32'(vramAddr), 32'd500);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_we",     32'(vramWe),     32'd0);
        checkOutput("mid_rst_ready",  32'(readyH),     32'd1);
        checkOutput("mid_rst_cursor", 32'(cursorAddr), 32'd0);
        checkOutput("mid_rst_vaddr",  32'(vramAddr),   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("partial_run", 32'(fillRunLen), 32'd500);
        weBase = weCount;
        applyStimulus(8'h03, 11'd0, 8'h00, 1'b0, 0, n, hi);
        checkOutput("reclr_pulses", 32'(weCount - weBase), 32'd2000);
        checkOutput("reclr_run",    32'(fillRunLen), 32'd2000);
        checkOutput("reclr_cursor", 32'(cursorAddr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
